// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: prescaled CE/period timing plus a duty ramp toward requested targets.
// Define PWM_DUTY_RAMP_EN to limit each period's duty change to STEP; otherwise the target loads at once.
`timescale 1ns/1ps
module pwm_duty_sequencer #(
  parameter int PWM_IN_SIZE = 10,
  parameter int PRESCALE = 50,
  parameter int STEP = 1
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   enable_in,
  input  logic                   req_valid_in,
  input  logic [PWM_IN_SIZE-1:0] req_duty_in,
  output logic                   req_ready_out,
  output logic                   CE_out,
  output logic                   synch_reset_out,
  output logic [PWM_IN_SIZE-1:0] PWM_data_out,
  output logic                   period_end_out,
  output logic                   busy_out
);
  typedef enum logic [1:0] {DISABLED, HOLD, RAMP} state_t;
  state_t r_state, w_next;
  logic [15:0] r_presc;
  logic [PWM_IN_SIZE-1:0] r_period, r_duty, r_target, w_duty, w_target, w_step;
  logic [PWM_IN_SIZE:0] w_mag, w_delta;
  logic r_ce, r_pend, r_sreset, r_busy, r_ready, w_run, w_tick, w_up;
  assign w_run = enable_in && !r_sreset;
  assign w_tick = w_run && (r_presc == 16'(PRESCALE - 1));
  assign w_up = r_target > r_duty;
  assign w_mag = w_up ? {1'b0, r_target} - {1'b0, r_duty} : {1'b0, r_duty} - {1'b0, r_target};
`ifdef PWM_DUTY_RAMP_EN
  assign w_delta = (w_mag > (PWM_IN_SIZE+1)'(STEP)) ? (PWM_IN_SIZE+1)'(STEP) : w_mag;
`else
  assign w_delta = w_mag;
`endif
  assign w_step = PWM_IN_SIZE'(w_up ? {1'b0, r_duty} + w_delta : {1'b0, r_duty} - w_delta);
  always_comb begin
    w_next = r_state;
    w_duty = r_duty;
    w_target = r_target;
    case (r_state)
      DISABLED: w_next = enable_in ? HOLD : DISABLED;
      HOLD: if (req_valid_in && r_ready) begin
        w_target = req_duty_in;
        w_next = (req_duty_in == r_duty) ? HOLD : RAMP;
      end
      RAMP: if (r_duty == r_target) w_next = HOLD;
        else if (r_pend) w_duty = w_step;
      default: w_next = DISABLED;
    endcase
    // a falling enable wins over any same-cycle period end
    if (!enable_in) begin
      w_next = DISABLED;
      w_duty = '0;
      w_target = '0;
    end
  end
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= DISABLED;
      r_presc <= '0;
      r_period <= '0;
      r_duty <= '0;
      r_target <= '0;
      r_ce <= 1'b0;
      r_pend <= 1'b0;
      r_sreset <= 1'b1;
      r_busy <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_duty <= w_duty;
      r_target <= w_target;
      r_presc <= (w_run && !w_tick) ? r_presc + 16'd1 : '0;
      r_period <= w_run ? r_period + PWM_IN_SIZE'(w_tick) : '0;
      r_ce <= w_tick;
      r_pend <= w_tick && (r_period == '1);
      r_sreset <= !enable_in;
      r_busy <= (w_next == RAMP);
      r_ready <= (w_next == HOLD);
    end
  end
  assign req_ready_out = r_ready;
  assign CE_out = r_ce;
  assign synch_reset_out = r_sreset;
  assign PWM_data_out = r_duty;
  assign period_end_out = r_pend;
  assign busy_out = r_busy;
endmodule

// File: doc/pwm_duty_sequencer.md
PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

Interface
REQ-001 SHALL have parameter PWM_IN_SIZE, default 10, the duty word width and PWM period exponent (period = 2**PWM_IN_SIZE CE ticks).
REQ-002 SHALL have parameter PRESCALE, default 50, the clk_in cycles per CE pulse (legal range 1..65535).
REQ-003 SHALL have parameter STEP, default 1, the maximum duty change per PWM period (legal range 1..2**PWM_IN_SIZE-1).
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_in, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port enable_in, input, 1 bit: run request; low stops and clears the PWM.
REQ-007 SHALL have port req_valid_in, input, 1 bit: a new target duty is offered.
REQ-008 SHALL have port req_duty_in, input, PWM_IN_SIZE bits: the target duty.
REQ-009 SHALL have port req_ready_out, output, 1 bit: a target can be accepted.
REQ-010 SHALL have port CE_out, output, 1 bit: a one-cycle clock-enable pulse to the PWM generator.
REQ-011 SHALL have port synch_reset_out, output, 1 bit: the synchronous reset to the PWM generator.
REQ-012 SHALL have port PWM_data_out, output, PWM_IN_SIZE bits: the current duty word.
REQ-013 SHALL have port period_end_out, output, 1 bit: a one-cycle pulse on the last CE tick of each PWM period.
REQ-014 SHALL have port busy_out, output, 1 bit: high while ramping.

Function
REQ-015 SHALL implement the FSM states DISABLED, HOLD and RAMP; every output SHALL be registered.
REQ-016 SHALL register synch_reset_out as the inverse of enable_in; while it is high, the prescale and period counters SHALL be held at 0.
REQ-017 SHALL run the prescale counter 0..PRESCALE-1 while enabled, and SHALL assert CE_out for one cycle when the count equals PRESCALE-1.
REQ-018 SHALL advance a PWM_IN_SIZE-bit period counter on each CE, wrapping from 2**PWM_IN_SIZE-1 to 0; period_end_out SHALL pulse with the CE that wraps it.
REQ-019 SHALL transition DISABLED->HOLD on the first cycle with enable_in high, and any state->DISABLED on the first cycle with enable_in low; on entering DISABLED, PWM_data_out SHALL be set to 0 and any pending target discarded.
REQ-020 SHALL drive req_ready_out high only in HOLD; a transfer occurs when req_valid_in and req_ready_out are both high, latching req_duty_in as the target.
REQ-021 SHALL stay in HOLD when an accepted target equals PWM_data_out, and SHALL otherwise go to RAMP with busy_out high from the next cycle.
REQ-022 SHALL, in RAMP, on each period_end_out cycle, move PWM_data_out toward the target by min(STEP, |target - current|), computed at PWM_IN_SIZE+1 bits with no wrap-around.
REQ-023 SHALL enter HOLD in the cycle after PWM_data_out equals the target, deasserting busy_out and asserting req_ready_out.
REQ-024 SHALL change PWM_data_out only on period_end_out cycles, entry to DISABLED, or reset.
REQ-025 SHALL give enable_in falling priority over a period_end_out in the same cycle, so PWM_data_out becomes 0.

Reset
REQ-026 SHALL, on reset_in high, immediately set state DISABLED, all counters 0, PWM_data_out 0, target 0, and CE_out, period_end_out, busy_out and req_ready_out 0, with synch_reset_out 1.
REQ-027 SHALL leave DISABLED after reset release only via REQ-019.

Configuration
REQ-028 SHALL ramp per REQ-022 when macro PWM_DUTY_RAMP_EN is defined; when it is undefined, RAMP SHALL load the full target at the next period_end_out, and STEP SHALL be unused.

Verification (PWM_IN_SIZE=4, PRESCALE=4, STEP=3, macro defined unless stated)
REQ-029 SHALL cover reset asserted mid-ramp -> all outputs per REQ-026 within the same cycle, with no clk_in edge required.
REQ-030 SHALL cover enable_in raised -> synch_reset_out low one cycle later, CE_out every 4 cycles, and period_end_out every 64 cycles.
REQ-031 SHALL cover a request of 10 from duty 0 -> PWM_data_out 3, 6, 9, 10 on four successive period_ends, then busy_out low and req_ready_out high.
REQ-032 SHALL cover a request of 1 from duty 10 -> PWM_data_out 7, 4, 1; and a request of 1 at duty 1 -> stays HOLD, with busy_out never high.
REQ-033 SHALL cover enable_in dropped during a ramp at duty 6 -> PWM_data_out 0, synch_reset_out 1, req_ready_out 0; on re-enable, HOLD is reached at duty 0.
REQ-034 SHALL cover the macro undefined with a request of 10 from 0 -> PWM_data_out jumps to 10 at the first period_end.
